sram_wb_ctrl: RTL and testbench

SRAM_WB_CTRL -- requirements
Module: sram_wb_ctrl

---
 rtl/sram_wb_ctrl.sv | 104 ++++++++++
 tb/tb_sram_wb_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_wb_ctrl.sv
// Wishbone-classic slave in front of BANKS x 4 byte-wide 512-word SRAM macros.
// Each transfer: request edge -> macro access edge -> ack cycle -> idle.
module sram_wb_ctrl #(
  parameter int  BANKS = 2,
  localparam int BBITS = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int ABITS = 9 + $clog2(BANKS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wb_cyc,
  input  logic                   wb_stb,
  input  logic                   wb_we,
  input  logic [3:0]             wb_sel,
  input  logic [ABITS-1:0]       wb_adr,
  input  logic [31:0]            wb_dat_w,
  output logic [31:0]            wb_dat_r,
  output logic                   wb_ack,
  output logic [4*BANKS-1:0]     sram_cen,
  output logic [4*BANKS-1:0]     sram_gwen,
  output logic [8*4*BANKS-1:0]   sram_wen,
  output logic [8:0]             sram_a,
  output logic [31:0]            sram_d,
  input  logic [32*BANKS-1:0]    sram_q
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t                 state, state_nxt;
  logic [BBITS-1:0]       bank_q, bank_nxt, req_bank;
  logic [4*BANKS-1:0]     cen_nxt, gwen_nxt;
  logic [8*4*BANKS-1:0]   wen_nxt;
  logic [8:0]             a_nxt;
  logic [31:0]            d_nxt;

  generate
    if (BANKS > 1) begin : g_bank
      assign req_bank = wb_adr[ABITS-1:9];
    end else begin : g_nobank
      assign req_bank = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bank_q    <= '0;
      sram_cen  <= '1;
      sram_gwen <= '1;
      sram_wen  <= '1;
      sram_a    <= '0;
      sram_d    <= '0;
    end else begin
      state     <= state_nxt;
      bank_q    <= bank_nxt;
      sram_cen  <= cen_nxt;
      sram_gwen <= gwen_nxt;
      sram_wen  <= wen_nxt;
      sram_a    <= a_nxt;
      sram_d    <= d_nxt;
    end
  end

  // Macro controls for the access are computed here and registered on the
  // request edge, so the macros fire on the edge that leaves ACCESS.
  always_comb begin
    state_nxt = state;
    bank_nxt  = bank_q;
    cen_nxt   = '1;
    gwen_nxt  = '1;
    wen_nxt   = '1;
    a_nxt     = sram_a;
    d_nxt     = sram_d;
    case (state)
      IDLE: begin
        if (wb_cyc && wb_stb) begin
          state_nxt = ACCESS;
          bank_nxt  = req_bank;
          a_nxt     = wb_adr[8:0];
          d_nxt     = wb_dat_w;
          for (int m = 0; m < 4*BANKS; m++) begin
            if (int'(req_bank) == m / 4) begin
              if (wb_we) begin
                if (wb_sel[m % 4]) begin
                  cen_nxt[m]       = 1'b0;
                  wen_nxt[m*8 +: 8] = 8'h00;
                end
              end else begin
                cen_nxt[m]  = 1'b0;
                gwen_nxt[m] = 1'b0;
              end
            end
          end
        end
      end
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wb_ack   = (state == ACK) & wb_cyc;
  assign wb_dat_r = sram_q[32*int'(bank_q) +: 32];

endmodule

// File: tb/tb_sram_wb_ctrl.sv
// Bench for sram_wb_ctrl: behavioural SRAM macros, a word-level reference
// memory with transfer-phase tracking, per-cycle compare, directed + random traffic.
module tb_sram_wb_ctrl;
  localparam int BANKS = 2;
  localparam int ABITS = 9 + $clog2(BANKS);
  localparam int NM    = 4*BANKS;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 wb_cyc, wb_stb, wb_we;
  logic [3:0]           wb_sel;
  logic [ABITS-1:0]     wb_adr;
  logic [31:0]          wb_dat_w, wb_dat_r;
  logic                 wb_ack;
  logic [NM-1:0]        sram_cen, sram_gwen;
  logic [8*NM-1:0]      sram_wen;
  logic [8:0]           sram_a;
  logic [31:0]          sram_d;
  logic [32*BANKS-1:0]  sram_q;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;
  logic clr    = 1'b1;

  sram_wb_ctrl #(.BANKS(BANKS)) dut (
    .clk(clk), .rst_n(rst_n), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
    .wb_ack(wb_ack), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  // Byte-wide macros with a registered Q output.
  logic [7:0] smem [0:NM-1][0:511];
  always @(posedge clk) begin
    if (clr) begin
      for (int m = 0; m < NM; m++)
        for (int r = 0; r < 512; r++) smem[m][r] <= 8'h00;
      sram_q <= '0;
    end else begin
      for (int m = 0; m < NM; m++) begin
        if (!sram_cen[m]) begin
          if (!sram_gwen[m]) sram_q[(m/4)*32 + (m%4)*8 +: 8] <= smem[m][sram_a];
          else
            for (int j = 0; j < 8; j++)
              if (!sram_wen[m*8+j]) smem[m][sram_a][j] <= sram_d[(m%4)*8+j];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: word memory plus the number of cycles since the request.
  logic [31:0]      ref_mem [0:(1<<ABITS)-1];
  int               phase = 0;      // 0 idle, 1 access cycle, 2 ack cycle
  logic             req_we;
  logic [3:0]       req_sel;
  logic [ABITS-1:0] req_adr;
  logic [8:0]       exp_a = '0;
  logic [31:0]      exp_d = '0;

  initial begin
    for (int i = 0; i < (1<<ABITS); i++) ref_mem[i] = 32'h0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        phase = 0; exp_a = '0; exp_d = '0;
      end else if (phase == 0) begin
        if (wb_cyc && wb_stb) begin
          phase = 1; req_we = wb_we; req_sel = wb_sel; req_adr = wb_adr;
          exp_a = wb_adr[8:0]; exp_d = wb_dat_w;
          if (wb_we)
            for (int l = 0; l < 4; l++)
              if (wb_sel[l]) ref_mem[wb_adr][l*8 +: 8] = wb_dat_w[l*8 +: 8];
        end
      end else if (phase == 1) phase = 2;
      else phase = 0;
    end
  end

  initial begin
    logic [NM-1:0]   e_cen, e_gwen;
    logic [8*NM-1:0] e_wen;
    int bank;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_cen = '1; e_gwen = '1; e_wen = '1;
        bank = int'(req_adr) >> 9;
        if (phase == 1)
          for (int m = 0; m < NM; m++)
            if (m / 4 == bank) begin
              if (!req_we) begin e_cen[m] = 1'b0; e_gwen[m] = 1'b0; end
              else if (req_sel[m%4]) begin e_cen[m] = 1'b0; e_wen[m*8 +: 8] = 8'h00; end
            end
        chk("ack", wb_ack, (phase == 2) && wb_cyc);
        chk("cen", sram_cen, e_cen);
        chk("gwen", sram_gwen, e_gwen);
        chk("wen", sram_wen, e_wen);
        chk("sram_a", sram_a, exp_a);
        chk("sram_d", sram_d, exp_d);
        if (phase == 2 && wb_cyc && !req_we) chk("dat_r", wb_dat_r, ref_mem[req_adr]);
      end
    end
  end

  task automatic xfer(input logic we, input logic [ABITS-1:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd, output int lat);
    @(posedge clk); #2;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
    @(posedge clk);
    lat = -1; rd = 'x;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (wb_ack) begin lat = k; rd = wb_dat_r; break; end
    end
    if (lat < 0) chk("ack_timeout", 0, 1);
    @(posedge clk); #2;
    wb_cyc = 0; wb_stb = 0;
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    int ackc [4];
    int na;
    rst_n = 0; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 0; wb_adr = 0; wb_dat_w = 0;
    repeat (2) @(posedge clk);
    #2 clr = 0; chk_en = 1;
    @(posedge clk); #2 rst_n = 1;

    // write then read back
    xfer(1, 10'h005, 32'hDEADBEEF, 4'hF, rd, lat); chk("lat_wr", lat, 2);
    xfer(0, 10'h005, 32'h0, 4'h0, rd, lat);        chk("lat_rd", lat, 2);
    chk("rd_deadbeef", rd, 32'hDEADBEEF);

    // partial byte-lane write
    xfer(1, 10'h010, 32'h11223344, 4'hF, rd, lat);
    xfer(1, 10'h010, 32'hAABBCCDD, 4'b0101, rd, lat);
    xfer(0, 10'h010, 32'h0, 4'hF, rd, lat);
    chk("rd_merge", rd, 32'h11BB33DD);

    // bank select
    xfer(1, 10'h003, 32'h1, 4'hF, rd, lat);
    xfer(1, 10'h203, 32'h2, 4'hF, rd, lat);
    xfer(0, 10'h003, 32'h0, 4'hF, rd, lat); chk("rd_bank0", rd, 32'h1);
    xfer(0, 10'h203, 32'h0, 4'hF, rd, lat); chk("rd_bank1", rd, 32'h2);

    // empty-sel write still acks
    xfer(1, 10'h003, 32'hFFFFFFFF, 4'h0, rd, lat); chk("lat_sel0", lat, 2);
    xfer(0, 10'h003, 32'h0, 4'hF, rd, lat);        chk("rd_sel0", rd, 32'h1);

    // strobe held for four writes
    @(posedge clk); #2;
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 10'h020; wb_dat_w = 32'h5A5A0001; wb_sel = 4'hF;
    @(posedge clk);
    na = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (wb_ack && na < 4) begin ackc[na] = k; na++; end
    end
    #1 wb_cyc = 0; wb_stb = 0;
    chk("b2b_count", na, 4);
    chk("b2b_ack0", ackc[0], 2);
    chk("b2b_ack1", ackc[1], 5);
    chk("b2b_ack2", ackc[2], 8);
    chk("b2b_ack3", ackc[3], 11);
    repeat (2) @(posedge clk);

    // cyc dropped during ACCESS
    @(posedge clk); #2;
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 10'h044; wb_dat_w = 32'hC0DE1234; wb_sel = 4'hF;
    @(posedge clk); #2 wb_cyc = 0; wb_stb = 0;
    repeat (3) @(posedge clk);
    xfer(0, 10'h044, 32'h0, 4'hF, rd, lat); chk("rd_cycdrop", rd, 32'hC0DE1234);

    // reset during ACCESS
    @(posedge clk); #2;
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 10'h230; wb_dat_w = 32'hCAFEF00D; wb_sel = 4'hF;
    @(posedge clk); #2 rst_n = 0; wb_cyc = 0; wb_stb = 0;
    @(posedge clk); #2 rst_n = 1;
    @(negedge clk);
    chk("rst_a", sram_a, 9'h0);
    chk("rst_cen", sram_cen, {NM{1'b1}});
    @(posedge clk);
    xfer(0, 10'h230, 32'h0, 4'hF, rd, lat);
    chk("lat_after_rst", lat, 2);
    chk("rd_after_rst", rd, 32'hCAFEF00D);

    // random traffic
    for (int t = 0; t < 150; t++) begin
      logic [ABITS-1:0] a;
      a = ABITS'(($urandom_range(0, 1) << 9) | $urandom_range(0, 15));
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd, lat);
      chk("lat_rand", lat, 2);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
